// File: rtl/texture_loader.sv
// Bus-side write engine: accepts 32-bit iomem stores of eight packed texels and
// serialises them into eight single-texel writes on the texture store write port.
module texture_loader #(
   parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        iomem_valid,
   output logic        iomem_ready,
   input  logic [3:0]  iomem_wstrb,
   input  logic [31:0] iomem_addr,
   input  logic [31:0] iomem_wdata,
   output logic [31:0] iomem_rdata,
   output logic        tex_wen,
   output logic [11:0] tex_waddr,
   output logic [2:0]  tex_wdata,
   output logic        busy
);

   localparam int unsigned WORD_W = 9;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned TEX_W  = 3;
   localparam int unsigned NTEX   = 8;
   localparam int unsigned PACK_W = NTEX * TEX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTEX - 1);

   typedef enum logic {IDLE, SEND} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [WORD_W-1:0]   word_q, word_d;
   logic [PACK_W-1:0]   data_q, data_d;
   logic [3:0]          strb_q, strb_d;
   logic                ready_d, wen_d, busy_d;
   logic [11:0]         waddr_d;
   logic [TEX_W-1:0]    wdata_d;
   logic [PACK_W-1:0]   packed_c;
   logic [IDX_W-1:0]    idx_nxt_c;
   logic                sel_c;
   logic                unused_c;

   assign iomem_rdata = 32'h0;
   assign sel_c = iomem_valid && (iomem_addr[31:24] == BASE_ADDR[31:24]);
   assign unused_c = ^{iomem_addr[23:11], iomem_addr[1:0],
                       iomem_wdata[31], iomem_wdata[27], iomem_wdata[23], iomem_wdata[19],
                       iomem_wdata[15], iomem_wdata[11], iomem_wdata[7], iomem_wdata[3]};

   // Drop the spare bit of each nibble so only 3-bit texels are latched
   always_comb begin
      packed_c = '0;
      for (int i = 0; i < int'(NTEX); i++) begin
         packed_c[i*TEX_W +: TEX_W] = iomem_wdata[i*4 +: TEX_W];
      end
   end

   assign idx_nxt_c = idx_q + IDX_W'(1);

   // Next-state and registered-output logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      data_d  = data_q;
      strb_d  = strb_q;
      ready_d = 1'b0;
      wen_d   = 1'b0;
      busy_d  = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
      case (state_q)
         IDLE: begin
            // The cycle after an ack still sees the held request; skip it
            if (sel_c && !iomem_ready) begin
               ready_d = 1'b1;
               if (iomem_wstrb != 4'b0000) begin
                  state_d = SEND;
                  idx_d   = '0;
                  word_d  = iomem_addr[10:2];
                  data_d  = packed_c;
                  strb_d  = iomem_wstrb;
                  busy_d  = 1'b1;
                  wen_d   = iomem_wstrb[0];
                  waddr_d = {iomem_addr[10:2], IDX_W'(0)};
                  wdata_d = packed_c[TEX_W-1:0];
               end
            end
         end
         SEND: begin
            if (idx_q == LAST_IDX) begin
               state_d = IDLE;
            end else begin
               idx_d   = idx_nxt_c;
               busy_d  = 1'b1;
               wen_d   = strb_q[idx_nxt_c[2:1]];
               waddr_d = {word_q, idx_nxt_c};
               wdata_d = data_q[TEX_W*idx_nxt_c +: TEX_W];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         word_q      <= '0;
         data_q      <= '0;
         strb_q      <= '0;
         iomem_ready <= 1'b0;
         tex_wen     <= 1'b0;
         tex_waddr   <= '0;
         tex_wdata   <= '0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         word_q      <= word_d;
         data_q      <= data_d;
         strb_q      <= strb_d;
         iomem_ready <= ready_d;
         tex_wen     <= wen_d;
         tex_waddr   <= waddr_d;
         tex_wdata   <= wdata_d;
         busy        <= busy_d;
      end
   end

endmodule

// File: tb/tb_texture_loader.sv
// Directed bench for texture_loader: bus handshakes, texel serialisation and a
// model texture store fed from the write port.
module tb_texture_loader;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        iomem_valid = 1'b0;
   logic        iomem_ready;
   logic [3:0]  iomem_wstrb = 4'h0;
   logic [31:0] iomem_addr = 32'h0;
   logic [31:0] iomem_wdata = 32'h0;
   logic [31:0] iomem_rdata;
   logic        tex_wen;
   logic [11:0] tex_waddr;
   logic [2:0]  tex_wdata;
   logic        busy;

   int total = 0;
   int bad = 0;

   logic [2:0] store [4096] = '{default: 3'd0};

   texture_loader dut (
      .clk(clk), .resetn(resetn),
      .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
      .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
      .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
      .tex_wen(tex_wen), .tex_waddr(tex_waddr), .tex_wdata(tex_wdata),
      .busy(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tex_wen) store[tex_waddr] <= tex_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      iomem_valid = 1'b1;
      iomem_addr  = a;
      iomem_wdata = d;
      iomem_wstrb = s;
   endtask

   // Entered in cycle 1 of a burst; leaves in cycle 9 (idle, next request may be taken)
   task automatic burst_check(input logic [11:0] base, input logic [7:0] wen,
                              input logic [23:0] tex, input bit nxt,
                              input logic [31:0] na, input logic [31:0] nd,
                              input logic [3:0] ns);
      logic [2:0] et;
      for (int i = 0; i < 8; i++) begin
         et = tex[i*3 +: 3];
         check($sformatf("ready[%0d]", i), 32'(iomem_ready), 32'(i == 0));
         check($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
         check($sformatf("wen[%0d]", i), 32'(tex_wen), 32'(wen[i]));
         check($sformatf("waddr[%0d]", i), 32'(tex_waddr), 32'(base + 12'(i)));
         check($sformatf("wdata[%0d]", i), 32'(tex_wdata), 32'(et));
         if (i == 0) iomem_valid = 1'b0;
         if (i == 1 && nxt) req(na, nd, ns);
         cyc();
      end
      check("end_ready", 32'(iomem_ready), 32'd0);
      check("end_wen", 32'(tex_wen), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset and idle
      repeat (3) cyc();
      resetn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         check("rst_ready", 32'(iomem_ready), 32'd0);
         check("rst_rdata", iomem_rdata, 32'd0);
         check("rst_wen", 32'(tex_wen), 32'd0);
         check("rst_waddr", 32'(tex_waddr), 32'd0);
         check("rst_wdata", 32'(tex_wdata), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         cyc();
      end

      // Full-lane write, word 4
      req(32'h0300_0010, 32'h7654_3210, 4'hF);
      cyc();
      burst_check(12'h020, 8'hFF, 24'o76543210, 1'b0, 0, 0, 0);
      for (int i = 0; i < 8; i++)
         check($sformatf("store_w4[%0d]", i), 32'(store[12'h020 + 12'(i)]), 32'(i));

      // Partial lanes, last word
      req(32'h0300_07FC, 32'hFFFF_FFFF, 4'b0101);
      cyc();
      burst_check(12'hFF8, 8'b0011_0011, 24'o77777777, 1'b0, 0, 0, 0);
      check("store_ff8", 32'(store[12'hFF8]), 32'd7);
      check("store_ffa", 32'(store[12'hFFA]), 32'd0);
      check("store_ffd", 32'(store[12'hFFD]), 32'd7);
      check("store_fff", 32'(store[12'hFFF]), 32'd0);

      // Back-to-back: second request raised in cycle 2, taken in cycle 9
      req(32'h0300_0020, 32'h1234_5670, 4'hF);
      cyc();
      burst_check(12'h040, 8'hFF, 24'o12345670, 1'b1, 32'h0300_0024, 32'h0765_4321, 4'hF);
      cyc();
      burst_check(12'h048, 8'hFF, 24'o07654321, 1'b0, 0, 0, 0);
      check("store_b2b_a", 32'(store[12'h041]), 32'd7);
      check("store_b2b_b", 32'(store[12'h04F]), 32'd0);

      // Read inside the window
      req(32'h0300_0000, 32'hDEAD_BEEF, 4'h0);
      cyc();
      check("rd_ready", 32'(iomem_ready), 32'd1);
      check("rd_rdata", iomem_rdata, 32'd0);
      check("rd_busy", 32'(busy), 32'd0);
      iomem_valid = 1'b0;
      cyc();
      check("rd_ready2", 32'(iomem_ready), 32'd0);
      check("rd_busy2", 32'(busy), 32'd0);

      // Access outside the window
      req(32'h0200_0000, 32'hFFFF_FFFF, 4'hF);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("oow_ready", 32'(iomem_ready), 32'd0);
         check("oow_wen", 32'(tex_wen), 32'd0);
         check("oow_busy", 32'(busy), 32'd0);
      end
      iomem_valid = 1'b0;
      cyc();

      // Reset in cycle 4 of a burst
      req(32'h0300_0100, 32'h7777_7777, 4'hF);
      cyc();
      check("mr_ready", 32'(iomem_ready), 32'd1);
      iomem_valid = 1'b0;
      cyc();
      cyc();
      cyc();
      check("mr_waddr_c4", 32'(tex_waddr), 32'h203);
      resetn = 1'b0;
      #1;
      check("mr_wen", 32'(tex_wen), 32'd0);
      check("mr_busy", 32'(busy), 32'd0);
      check("mr_ready0", 32'(iomem_ready), 32'd0);
      cyc();
      cyc();
      resetn = 1'b1;
      cyc();
      for (int i = 0; i < 8; i++)
         check($sformatf("store_mr[%0d]", i), 32'(store[12'h200 + 12'(i)]),
               (i < 3) ? 32'd7 : 32'd0);

      // Normal write after the interrupted one
      req(32'h0300_0104, 32'h7654_3210, 4'hF);
      cyc();
      burst_check(12'h208, 8'hFF, 24'o76543210, 1'b0, 0, 0, 0);
      check("store_post", 32'(store[12'h20F]), 32'd7);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
